// File: rtl/trivium_seq_ctrl.sv
// trivium_seq_ctrl: loads key/IV bytes, strobes the trivium core, warms it up and packs keystream bits into bytes
module trivium_seq_ctrl #(
  parameter int KEY_BYTES = 10,
  parameter int IV_BYTES = 10,
  parameter int WARMUP_CYCLES = 1152
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   restart,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             ks_data,
  output logic                   ks_valid,
  input  logic                   ks_ready,
  output logic [8*KEY_BYTES-1:0] core_key,
  output logic [8*IV_BYTES-1:0]  core_iv,
  output logic                   core_load,
  output logic                   core_en,
  input  logic                   core_ks,
  output logic                   busy
);
  localparam logic [2:0] S_LOAD_KEY = 3'd0, S_LOAD_IV = 3'd1, S_INIT = 3'd2, S_WARMUP = 3'd3, S_RUN = 3'd4;
  localparam int BW = $clog2((KEY_BYTES > IV_BYTES ? KEY_BYTES : IV_BYTES) + 1);
  localparam int WW = $clog2(WARMUP_CYCLES);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
  logic [2:0] state, state_n;
  logic [BW-1:0] byte_cnt;
  logic [WW-1:0] warm_cnt;
  logic [3:0] bit_cnt, bit_n;
  logic [7:0] acc;
  logic xfer, last_byte, warm_done, collect, handoff;
  assign in_ready = state == S_LOAD_KEY || state == S_LOAD_IV;
  assign xfer = in_valid && in_ready;
  assign last_byte = state == S_LOAD_KEY ? byte_cnt == BW'(KEY_BYTES - 1) : byte_cnt == BW'(IV_BYTES - 1);
  assign warm_done = warm_cnt == WARM_LAST;
  assign collect = state == S_RUN && !bit_cnt[3];
  assign handoff = state == S_RUN && bit_cnt[3] && (!ks_valid || ks_ready);
  always_comb begin
    state_n = restart ? S_LOAD_KEY :
              (state == S_LOAD_KEY && xfer && last_byte) ? S_LOAD_IV :
              (state == S_LOAD_IV && xfer && last_byte) ? S_INIT :
              state == S_INIT ? S_WARMUP :
              (state == S_WARMUP && warm_done) ? S_RUN : state;
    bit_n = (restart || handoff) ? 4'd0 : collect ? bit_cnt + 4'd1 : bit_cnt;
  end
  // outputs are registered from the next-state view so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD_KEY;
      byte_cnt <= '0;
      warm_cnt <= '0;
      bit_cnt <= '0;
      acc <= '0;
      core_key <= '0;
      core_iv <= '0;
      ks_data <= '0;
      ks_valid <= 1'b0;
      core_load <= 1'b0;
      core_en <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_n;
      byte_cnt <= (restart || (xfer && last_byte)) ? '0 : xfer ? byte_cnt + 1'b1 : byte_cnt;
      warm_cnt <= (state == S_WARMUP && !restart && !warm_done) ? warm_cnt + 1'b1 : '0;
      for (int i = 0; i < KEY_BYTES; i++)
        if (!restart && xfer && state == S_LOAD_KEY && byte_cnt == BW'(i)) core_key[8*i +: 8] <= in_data;
      for (int i = 0; i < IV_BYTES; i++)
        if (!restart && xfer && state == S_LOAD_IV && byte_cnt == BW'(i)) core_iv[8*i +: 8] <= in_data;
      if (collect && !restart) acc[bit_cnt[2:0]] <= core_ks;
      if (handoff && !restart) ks_data <= acc;
      ks_valid <= restart ? 1'b0 : handoff ? 1'b1 : ks_ready ? 1'b0 : ks_valid;
      core_load <= state_n == S_INIT;
      busy <= state_n == S_WARMUP;
      core_en <= state_n == S_WARMUP || (state_n == S_RUN && !bit_n[3]);
    end
  end
endmodule
